mul_share_ctrl: RTL

- Shares one start/done 16-bit arithmetic core among NREQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the core through a clear pulse, a start pulse and a wait for done, then returns the result with a one-cycle ack tagged with the requester id.
- Sits between the requester blocks and the single core instance inside the top level, replacing manual per-operation reset/start sequencing.

---
 rtl/mul_share_ctrl_pkg.sv | 23 ++
 rtl/mul_share_ctrl_if.sv | 47 ++++
 rtl/mul_share_ctrl_rr_picker.sv | 43 ++++
 rtl/mul_share_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mul_share_ctrl_pkg.sv
// Shared types and defaults for the multiplier-sharing controller.
// The state encoding is fixed so that debug probes read the same on every build.
package mul_share_pkg;

   localparam int NREQ_DEF    = 4;
   localparam int W_DEF       = 16;
   localparam int TIMEOUT_DEF = 1023;
   localparam int CNT_W       = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLR    = 3'd1,
      LAUNCH = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4
   } state_t;

   // Id width for n requesters; a single bit is kept even for n <= 2.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Requester-side and core-side bundles of the multiplier-sharing controller.
// The master of each bundle is the side that drives the request/command.
interface mul_share_req_if #(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   ack;
   logic [W-1:0]      res_y;
   logic [IDW-1:0]    res_id;
   logic              res_err;
   logic              busy;

   modport master (
      output req, req_a, req_b,
      input  ack, res_y, res_id, res_err, busy
   );

   modport slave (
      input  req, req_a, req_b,
      output ack, res_y, res_id, res_err, busy
   );
endinterface

interface mul_share_core_if #(
   parameter int W = 16
);
   logic         core_rst;
   logic         core_start;
   logic [W-1:0] core_a;
   logic [W-1:0] core_b;
   logic [W-1:0] core_y;
   logic         core_done;

   modport master (
      output core_rst, core_start, core_a, core_b,
      input  core_y, core_done
   );

   modport slave (
      input  core_rst, core_start, core_a, core_b,
      output core_y, core_done
   );
endinterface

// File: rtl/mul_share_ctrl_rr_picker.sv
// Round-robin search: rotate req so index ptr sits at bit 0, take the lowest
// set bit, then map the offset back to an absolute requester id.
module rr_picker #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            valid,
   output logic [IDW-1:0]  gid
);
   localparam logic [IDW:0] NREQ_X = (IDW+1)'(NREQ);

   logic [NREQ-1:0] rot;
   logic [IDW-1:0]  off;
   logic [IDW:0]    sum;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_rot
         logic [IDW:0]   raw;
         logic [IDW-1:0] src;
         assign raw     = {1'b0, ptr} + (IDW+1)'(gi);
         assign src     = (raw >= NREQ_X) ? IDW'(raw - NREQ_X) : raw[IDW-1:0];
         assign rot[gi] = req[src];
      end
   endgenerate

   // Descending scan so the lowest set offset is the one left standing.
   always_comb begin
      off = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = IDW'(i);
         end
      end
   end

   assign valid = |req;
   assign sum   = {1'b0, ptr} + {1'b0, off};
   assign gid   = (sum >= NREQ_X) ? IDW'(sum - NREQ_X) : sum[IDW-1:0];

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one start/done arithmetic core among NREQ requesters: round-robin grant,
// clear pulse, start pulse, bounded wait for done, then a one-cycle tagged ack.
module mul_share_ctrl
   import mul_share_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int W       = W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int IDW     = id_width(NREQ)
) (
   input  logic             clk,
   input  logic             rst,
   mul_share_req_if.slave   rq,
   mul_share_core_if.master cr
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [IDW-1:0]   ID_LAST  = IDW'(NREQ - 1);

   state_t          state_reg;
   state_t          state_next;
   logic [IDW-1:0]  ptr_reg;
   logic [IDW-1:0]  gid_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [W-1:0]    res_y_reg;
   logic            res_err_reg;
   logic [IDW-1:0]  res_id_reg;
   logic [NREQ-1:0] ack_reg;

   logic            pick_valid;
   logic [IDW-1:0]  pick_gid;
   logic            grant;
   logic            done_hit;
   logic            timeout_hit;

   logic [W-1:0]    a_slice [NREQ];
   logic [W-1:0]    b_slice [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_slice
         assign a_slice[gi] = rq.req_a[gi*W +: W];
         assign b_slice[gi] = rq.req_b[gi*W +: W];
      end
   endgenerate

   rr_picker #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req   (rq.req),
      .ptr   (ptr_reg),
      .valid (pick_valid),
      .gid   (pick_gid)
   );

   assign grant       = (state_reg == IDLE) && pick_valid;
   assign done_hit    = (state_reg == WAIT) && cr.core_done;
   // Done takes priority when it lands on the last counted cycle.
   assign timeout_hit = (state_reg == WAIT) && !cr.core_done && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (pick_valid) state_next = CLR;
         CLR:     state_next = LAUNCH;
         LAUNCH:  state_next = WAIT;
         WAIT:    if (done_hit || timeout_hit) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      rq.busy       = (state_reg != IDLE);
      cr.core_rst   = (state_reg == CLR);
      cr.core_start = (state_reg == LAUNCH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_reg     <= '0;
         gid_reg     <= '0;
         cnt_reg     <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         res_y_reg   <= '0;
         res_err_reg <= 1'b0;
         res_id_reg  <= '0;
         ack_reg     <= '0;
      end else begin
         ack_reg <= '0;
         if (grant) begin
            gid_reg <= pick_gid;
            ptr_reg <= (pick_gid == ID_LAST) ? '0 : pick_gid + 1'b1;
            a_reg   <= a_slice[pick_gid];
            b_reg   <= b_slice[pick_gid];
         end
         if (state_reg == LAUNCH) begin
            cnt_reg <= '0;
         end else if (state_reg == WAIT) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (done_hit || timeout_hit) begin
            ack_reg     <= NREQ'(1) << gid_reg;
            res_id_reg  <= gid_reg;
            res_y_reg   <= done_hit ? cr.core_y : '0;
            res_err_reg <= timeout_hit;
         end
      end
   end

   assign rq.ack     = ack_reg;
   assign rq.res_y   = res_y_reg;
   assign rq.res_id  = res_id_reg;
   assign rq.res_err = res_err_reg;
   assign cr.core_a  = a_reg;
   assign cr.core_b  = b_reg;

endmodule
